regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Next-generation picoMIPS register file. Has a parametrised number of read ports and two write ports.
- Register %0 is hardwired to zero.
- Optional write-to-read bypass and optional registered read outputs.
- Per-register busy scoreboard for multi-cycle producers.
- Sits between decode (read addresses, busy query) and writeback (ALU on port 0, multi-cycle/load unit on port 1).

Parameters:
- BUS_WIDTH, 8, data width in bits
- ADDR_WIDTH, 5, address width; register count N = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read (one clk)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- we0  in  1  write enable, port 0
- wa0  in  ADDR_WIDTH  write address, port 0
- wd0  in  BUS_WIDTH  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  ADDR_WIDTH  write address, port 1
- wd1  in  BUS_WIDTH  write data, port 1
- ra  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k = ra[k*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NUM_RD*BUS_WIDTH  packed read data, same packing as ra
- rbusy  out  NUM_RD  busy bit of the register addressed by each read port (combinational, always)
- bset  in  1  mark register busy (issue of a multi-cycle producer)
- baddr  in  ADDR_WIDTH  register to mark busy
- busy  out  N  full scoreboard vector; bit 0 is constant 0

Behaviour:
- Reset (rst=1, asynchronous):
  - all registers = 0, all busy bits = 0.
  - With READ_LATENCY=1, the rdata registers = 0.
  - Reset mid-write: the write is discarded. First write accepted on the first rising edge after rst deasserts.
- Writes:
  - Committed on the rising clk edge when weX=1.
  - Write to address 0 is ignored; %0 always reads 0.
  - Both ports enabled with equal address: port 1 data is stored and port 0 is dropped.
  - Different addresses: both are stored in the same cycle.
- Reads, READ_LATENCY=0:
  - rdata[k] follows ra[k] combinationally.
  - Address 0 returns 0.
  - BYPASS=1 and the address matches an enabled write this cycle: return the write data (port 1 takes priority over port 0). Address 0 is never bypassed.
  - BYPASS=0: return the stored value, which still holds old data until the edge.
- Reads, READ_LATENCY=1:
  - rdata[k] is registered and reflects ra[k] sampled at the previous edge.
  - BYPASS=1: the registered value includes same-cycle write data (new value).
  - BYPASS=0: the registered value is the old stored value.
- Scoreboard:
  - On the clk edge, bset=1 with baddr≠0 sets busy[baddr].
  - A committed write (after port-collision resolution; the dropped port-0 write also clears) clears busy[waX].
  - bset and a clearing write to the same address in the same cycle: set wins and the bit remains 1 (new producer issued).
  - bset with baddr=0 is ignored.
  - A write to a non-busy register is legal and leaves the bit at 0.
  - rbusy[k] = busy[ra[k]], using the current state and unaffected by READ_LATENCY.
- No internal state machine beyond the storage and busy flops. All outputs are deterministic with no X after reset.

Test Plan:
- Reset → rst pulse mid-cycle while we0=1, wa0=3, wd0=8'hAA → after reset reg3 reads 0, busy=0, rdata=0.
- Write/read, BYPASS=0, LAT=0 → we0=1, wa0=5, wd0=8'h3C, ra0=5: old value 0 before the edge, 8'h3C after. Write to %0 of 8'hFF → reads 0.
- Collision → we0=1, we1=1, both addr 7, wd0=8'h11, wd1=8'h22 → reg7=8'h22.
- Bypass, BYPASS=1, LAT=0 and LAT=1 → write 8'h5A to reg9 while ra1=9:
  - LAT=0: rdata1=8'h5A in the same cycle.
  - LAT=1: rdata1=8'h5A one cycle later.
  - Reads of ra=0 during a port-0 write to reg0 → 0.
- Scoreboard:
  - bset, baddr=4 → busy[4]=1 next cycle and rbusy=1 for ra=4.
  - we1 to reg4 → busy[4]=0.
  - Same-cycle bset=4 plus we0 to 4 → busy[4] stays 1.
  - bset, baddr=0 → no change.
- Port sweep, NUM_RD=4 → random concurrent writes/reads (10k cycles) checked against a reference model, both latency settings.

Source files
------------

// File: rtl/regfile_mp.sv
// picoMIPS register file: NUM_RD read ports, two write ports (port 1 wins on
// collision), %0 hardwired to zero, optional bypass / registered reads, busy scoreboard.

module regfile_mp_rd #(
    parameter int BUS_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int N            = 32,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          ra,
    input  logic [N-1:0][BUS_WIDTH-1:0]    mem,
    input  logic [N-1:0]                   busy,
    input  logic                           we0,
    input  logic [ADDR_WIDTH-1:0]          wa0,
    input  logic [BUS_WIDTH-1:0]           wd0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [BUS_WIDTH-1:0]           wd1,
    output logic [BUS_WIDTH-1:0]           rdata,
    output logic                           rbusy
);
    logic [BUS_WIDTH-1:0] rd_c;
    logic [BUS_WIDTH-1:0] rd_q;

    // Port 1 is checked first so it shadows port 0, matching the commit priority.
    always_comb begin
        rd_c = mem[ra];
        if (BYPASS != 0) begin
            if (we1 && wa1 == ra)
                rd_c = wd1;
            else if (we0 && wa0 == ra)
                rd_c = wd0;
        end
        if (ra == '0)
            rd_c = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_q <= '0;
        else
            rd_q <= rd_c;
    end

    assign rdata = (READ_LATENCY != 0) ? rd_q : rd_c;
    assign rbusy = busy[ra];
endmodule

module regfile_mp #(
    parameter int BUS_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD       = 2,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we0,
    input  logic [ADDR_WIDTH-1:0]          wa0,
    input  logic [BUS_WIDTH-1:0]           wd0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          wa1,
    input  logic [BUS_WIDTH-1:0]           wd1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   ra,
    output logic [NUM_RD*BUS_WIDTH-1:0]    rdata,
    output logic [NUM_RD-1:0]              rbusy,
    input  logic                           bset,
    input  logic [ADDR_WIDTH-1:0]          baddr,
    output logic [2**ADDR_WIDTH-1:0]       busy
);
    localparam int N = 2**ADDR_WIDTH;

    logic [N-1:0][BUS_WIDTH-1:0] mem;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            for (int i = 1; i < N; i++) begin
                if (we1 && wa1 == ADDR_WIDTH'(i))
                    mem[i] <= wd1;
                else if (we0 && wa0 == ADDR_WIDTH'(i))
                    mem[i] <= wd0;
                // A new producer issued alongside the old one's writeback keeps the bit set.
                if (bset && baddr == ADDR_WIDTH'(i))
                    busy[i] <= 1'b1;
                else if ((we0 && wa0 == ADDR_WIDTH'(i)) || (we1 && wa1 == ADDR_WIDTH'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_mp_rd #(
            .BUS_WIDTH   (BUS_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .N           (N),
            .BYPASS      (BYPASS),
            .READ_LATENCY(READ_LATENCY)
        ) u_rd (
            .clk  (clk),
            .rst  (rst),
            .ra   (ra[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem  (mem),
            .busy (busy),
            .we0  (we0),
            .wa0  (wa0),
            .wd0  (wd0),
            .we1  (we1),
            .wa1  (wa1),
            .wd1  (wd1),
            .rdata(rdata[k*BUS_WIDTH +: BUS_WIDTH]),
            .rbusy(rbusy[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four configurations share one stimulus stream
// (no-bypass/comb, bypass/comb, bypass/registered, no-bypass/registered).

module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1, bset;
    logic [4:0]  wa0, wa1, baddr;
    logic [7:0]  wd0, wd1;
    logic [19:0] ra;

    logic [15:0] rdata0;
    logic [31:0] rdata1, rdata2, rdata3;
    logic [1:0]  rbusy0;
    logic [3:0]  rbusy1, rbusy2, rbusy3;
    logic [31:0] busy0, busy1, busy2, busy3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BUS_WIDTH(8), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0), .READ_LATENCY(0)) d0 (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra[9:0]), .rdata(rdata0), .rbusy(rbusy0), .bset(bset), .baddr(baddr), .busy(busy0));
    regfile_mp #(.BUS_WIDTH(8), .ADDR_WIDTH(5), .NUM_RD(4), .BYPASS(1), .READ_LATENCY(0)) d1 (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rdata(rdata1), .rbusy(rbusy1), .bset(bset), .baddr(baddr), .busy(busy1));
    regfile_mp #(.BUS_WIDTH(8), .ADDR_WIDTH(5), .NUM_RD(4), .BYPASS(1), .READ_LATENCY(1)) d2 (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rdata(rdata2), .rbusy(rbusy2), .bset(bset), .baddr(baddr), .busy(busy2));
    regfile_mp #(.BUS_WIDTH(8), .ADDR_WIDTH(5), .NUM_RD(4), .BYPASS(0), .READ_LATENCY(1)) d3 (
        .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rdata(rdata3), .rbusy(rbusy3), .bset(bset), .baddr(baddr), .busy(busy3));

    typedef struct {
        logic       we0;  logic [4:0] wa0; logic [7:0] wd0;
        logic       we1;  logic [4:0] wa1; logic [7:0] wd1;
        logic       bset; logic [4:0] baddr;
        logic [4:0] ra0;  logic [4:0] ra1;
        logic [7:0] nb0;  logic [7:0] nb1;   // expected, no bypass
        logic [7:0] by0;  logic [7:0] by1;   // expected, bypass
        logic [1:0] rb;   logic [31:0] bz;   // expected rbusy / busy before the edge
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        bset = 1'b0; baddr = '0; ra = '0;
    endtask

    // Reference model for the random sweep.
    logic [7:0]  m [32];
    logic [31:0] mb;

    function automatic logic [7:0] ev(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 8'h00;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m[a];
    endfunction

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    logic [15:0] pnb, pby;
    logic [31:0] e_nb, e_by, p_nb, p_by, e_rb32;
    logic [3:0]  e_rb;

    initial begin
        //               we0  wa0    wd0    we1  wa1    wd1    bset baddr  ra0    ra1    nb0    nb1    by0    by1    rb     bz
        tbl[0]  = '{1'b1, 5'd5,  8'h3C, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0, 5'd5,  5'd0,  8'h00, 8'h00, 8'h3C, 8'h00, 2'b00, 32'h0};
        tbl[1]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0, 5'd5,  5'd0,  8'h3C, 8'h00, 8'h3C, 8'h00, 2'b00, 32'h0};
        tbl[2]  = '{1'b1, 5'd0,  8'hFF, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0, 5'd0,  5'd5,  8'h00, 8'h3C, 8'h00, 8'h3C, 2'b00, 32'h0};
        tbl[3]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0, 5'd0,  5'd5,  8'h00, 8'h3C, 8'h00, 8'h3C, 2'b00, 32'h0};
        tbl[4]  = '{1'b1, 5'd7,  8'h11, 1'b1, 5'd7,  8'h22, 1'b0, 5'd0, 5'd7,  5'd7,  8'h00, 8'h00, 8'h22, 8'h22, 2'b00, 32'h0};
        tbl[5]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd9,  8'h5A, 1'b0, 5'd0, 5'd7,  5'd9,  8'h22, 8'h00, 8'h22, 8'h5A, 2'b00, 32'h0};
        tbl[6]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  8'h00, 1'b1, 5'd4, 5'd4,  5'd9,  8'h00, 8'h5A, 8'h00, 8'h5A, 2'b00, 32'h0};
        tbl[7]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd4,  8'h44, 1'b0, 5'd0, 5'd4,  5'd7,  8'h00, 8'h22, 8'h44, 8'h22, 2'b01, 32'h10};
        tbl[8]  = '{1'b1, 5'd4,  8'h55, 1'b0, 5'd0,  8'h00, 1'b1, 5'd4, 5'd4,  5'd0,  8'h44, 8'h00, 8'h55, 8'h00, 2'b00, 32'h0};
        tbl[9]  = '{1'b1, 5'd3,  8'h33, 1'b0, 5'd0,  8'h00, 1'b1, 5'd0, 5'd4,  5'd3,  8'h55, 8'h00, 8'h55, 8'h33, 2'b01, 32'h10};
        tbl[10] = '{1'b1, 5'd10, 8'hA0, 1'b1, 5'd11, 8'hB1, 1'b0, 5'd0, 5'd10, 5'd11, 8'h00, 8'h00, 8'hA0, 8'hB1, 2'b00, 32'h10};
        tbl[11] = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0, 5'd10, 5'd11, 8'hA0, 8'hB1, 8'hA0, 8'hB1, 2'b00, 32'h10};
        tbl[12] = '{1'b1, 5'd4,  8'h66, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0, 5'd4,  5'd9,  8'h55, 8'h5A, 8'h66, 8'h5A, 2'b01, 32'h10};
        tbl[13] = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 5'd0, 5'd4,  5'd3,  8'h66, 8'h33, 8'h66, 8'h33, 2'b00, 32'h0};

        // ---------------- reset, including an async assert during a write
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy0, 32'h0);
        chk("reset_rdata_lat1", rdata2, 32'h0);
        @(posedge clk); #1;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 8'h77; bset = 1'b1; baddr = 5'd3; ra = 20'd3;
        @(posedge clk); #1;
        wd0 = 8'hAA; bset = 1'b0;
        @(negedge clk);
        chk("pre_rst_rd", {24'h0, rdata0[7:0]}, 32'h77);
        chk("pre_rst_busy", busy0, 32'h8);
        chk("pre_rst_rbusy", {30'h0, rbusy0}, 32'h1);
        chk("pre_rst_lat1", {24'h0, rdata2[7:0]}, 32'h77);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rd", {24'h0, rdata0[7:0]}, 32'h0);
        chk("async_rst_lat1", rdata2, 32'h0);
        chk("async_rst_busy", busy0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; we0 = 1'b0;
        @(negedge clk);
        chk("post_rst_reg3", {24'h0, rdata0[7:0]}, 32'h0);
        chk("post_rst_reg3_byp", {24'h0, rdata1[7:0]}, 32'h0);
        chk("post_rst_lat1", rdata2, 32'h0);
        chk("post_rst_busy", busy0, 32'h0);
        @(posedge clk); #1;

        // ---------------- directed table
        pnb = '0; pby = '0;
        for (int i = 0; i < 14; i++) begin
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            bset = tbl[i].bset; baddr = tbl[i].baddr;
            ra = {10'h0, tbl[i].ra1, tbl[i].ra0};
            @(negedge clk);
            chk($sformatf("v%0d_nobyp", i), {16'h0, rdata0}, {16'h0, tbl[i].nb1, tbl[i].nb0});
            chk($sformatf("v%0d_byp", i), {16'h0, rdata1[15:0]}, {16'h0, tbl[i].by1, tbl[i].by0});
            chk($sformatf("v%0d_lat1_byp", i), {16'h0, rdata2[15:0]}, {16'h0, pby});
            chk($sformatf("v%0d_lat1_nobyp", i), {16'h0, rdata3[15:0]}, {16'h0, pnb});
            chk($sformatf("v%0d_rbusy", i), {30'h0, rbusy0}, {30'h0, tbl[i].rb});
            chk($sformatf("v%0d_rbusy_lat1", i), {30'h0, rbusy2[1:0]}, {30'h0, tbl[i].rb});
            chk($sformatf("v%0d_busy", i), busy0, tbl[i].bz);
            pnb = {tbl[i].nb1, tbl[i].nb0};
            pby = {tbl[i].by1, tbl[i].by0};
            @(posedge clk); #1;
        end

        // ---------------- random sweep against the model
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) m[i] = 8'h00;
        mb = '0; p_nb = '0; p_by = '0;
        for (int c = 0; c < 10000; c++) begin
            we0 = 1'($urandom_range(0, 1)); wa0 = raddr(); wd0 = 8'($urandom);
            we1 = 1'($urandom_range(0, 1)); wa1 = raddr(); wd1 = 8'($urandom);
            bset = ($urandom_range(0, 3) == 0); baddr = raddr();
            ra = {raddr(), raddr(), raddr(), raddr()};
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                e_nb[k*8 +: 8] = ev(ra[k*5 +: 5], 1'b0);
                e_by[k*8 +: 8] = ev(ra[k*5 +: 5], 1'b1);
                e_rb[k]        = mb[ra[k*5 +: 5]];
            end
            e_rb32 = {28'h0, e_rb};
            chk("rnd_nobyp", {16'h0, rdata0}, {16'h0, e_nb[15:0]});
            chk("rnd_byp", rdata1, e_by);
            chk("rnd_lat1_byp", rdata2, p_by);
            chk("rnd_lat1_nobyp", rdata3, p_nb);
            chk("rnd_rbusy2", {30'h0, rbusy0}, {30'h0, e_rb[1:0]});
            chk("rnd_rbusy", {28'h0, rbusy1}, e_rb32);
            chk("rnd_rbusy_lat1", {28'h0, rbusy2}, e_rb32);
            chk("rnd_busy", busy3, mb);
            p_nb = e_nb; p_by = e_by;
            if (we0) begin m[wa0] = wd0; mb[wa0] = 1'b0; end
            if (we1) begin m[wa1] = wd1; mb[wa1] = 1'b0; end
            if (bset) mb[baddr] = 1'b1;
            m[0] = 8'h00; mb[0] = 1'b0;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
